burst_addr_ctrl: RTL

Parametrised burst address sequencer for the SPS burst path, successor to the simple burst-length stop comparator. It accepts a burst command (base address, length, mode), steps an address counter one beat per downstream handshake, and flags the last beat and completion itself. This replaces the separate control/compare split and its off-by-one stop. It sits between the SPS command decoder and the MRAM access interface.

---
 rtl/burst_addr_ctrl.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/burst_addr_ctrl.sv
// burst_addr_ctrl
//   Burst address sequencer: latches a burst command (base, length, mode),
//   issues one address per downstream handshake, flags the final beat and
//   pulses done once the final beat is accepted.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   start                 command strobe (honoured only in IDLE, abort low)
//   base_addr, burst_len  first address, beats minus one
//   mode                  00 INCR, 01 WRAP, 10 FIXED, 11 reserved
//   abort                 terminate running burst / block start
//   beat_ready            downstream accepts current beat
//   addr, addr_valid      current beat address and its qualifier
//   last, beat_cnt        final-beat flag, 0-based beat index
//   busy, done, cfg_err   RUN|DONE, completion pulse, rejected-start pulse
module burst_addr_ctrl #(
  parameter int unsigned ADDR_WIDTH    = 8,
  parameter int unsigned COUNTER_WIDTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [ADDR_WIDTH-1:0]    base_addr,
  input  logic [COUNTER_WIDTH-1:0] burst_len,
  input  logic [1:0]               mode,
  input  logic                     abort,
  input  logic                     beat_ready,
  output logic [ADDR_WIDTH-1:0]    addr,
  output logic                     addr_valid,
  output logic                     last,
  output logic [COUNTER_WIDTH-1:0] beat_cnt,
  output logic                     busy,
  output logic                     done,
  output logic                     cfg_err
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
  typedef enum logic [1:0] {
    M_INCR  = 2'b00,
    M_WRAP  = 2'b01,
    M_FIXED = 2'b10,
    M_RSVD  = 2'b11
  } mode_e;

  state_e                   state_q, state_d;
  logic [ADDR_WIDTH-1:0]    addr_q, addr_d;
  logic [COUNTER_WIDTH-1:0] cnt_q, cnt_d;
  logic [COUNTER_WIDTH-1:0] len_q, len_d;
  mode_e                    mode_q, mode_d;
  logic                     cfg_err_q, cfg_err_d;

  logic [COUNTER_WIDTH-1:0] len_p1;
  logic                     pow2_len;
  logic                     cfg_ok;
  logic                     start_ok;
  logic                     accept;
  logic                     is_last;
  logic [ADDR_WIDTH-1:0]    wrap_mask;
  logic [ADDR_WIDTH-1:0]    addr_inc;
  logic [ADDR_WIDTH-1:0]    addr_step;

  // len+1 is a power of two iff len has no bit in common with len+1;
  // the all-ones length overflows to zero, which is correctly accepted.
  assign len_p1   = burst_len + COUNTER_WIDTH'(1);
  assign pow2_len = (burst_len & len_p1) == '0;

  always_comb begin
    cfg_ok = 1'b0;
    case (mode_e'(mode))
      M_INCR:  cfg_ok = 1'b1;
      M_FIXED: cfg_ok = 1'b1;
      M_WRAP:  cfg_ok = pow2_len;
      default: cfg_ok = 1'b0;
    endcase
  end

  assign start_ok = (state_q == IDLE) && start && !abort;
  assign accept   = (state_q == RUN) && beat_ready;
  assign is_last  = (cnt_q == len_q);

  // Wrap keeps the upper address bits and lets only the low (len+1)-aligned
  // field count, so an unaligned base wraps back to the block start.
  assign wrap_mask = ADDR_WIDTH'(len_q);
  assign addr_inc  = addr_q + ADDR_WIDTH'(1);

  always_comb begin
    addr_step = addr_q;
    case (mode_q)
      M_INCR:  addr_step = addr_inc;
      M_WRAP:  addr_step = (addr_q & ~wrap_mask) | (addr_inc & wrap_mask);
      default: addr_step = addr_q;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (start_ok && cfg_ok) state_d = RUN;
      RUN: begin
        if (abort)                  state_d = IDLE;
        else if (accept && is_last) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath next values
  always_comb begin
    addr_d    = addr_q;
    cnt_d     = cnt_q;
    len_d     = len_q;
    mode_d    = mode_q;
    cfg_err_d = start_ok && !cfg_ok;
    if (start_ok && cfg_ok) begin
      addr_d = base_addr;
      cnt_d  = '0;
      len_d  = burst_len;
      mode_d = mode_e'(mode);
    end else if (accept && !is_last) begin
      addr_d = addr_step;
      cnt_d  = cnt_q + COUNTER_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q    <= '0;
      cnt_q     <= '0;
      len_q     <= '0;
      mode_q    <= M_INCR;
      cfg_err_q <= 1'b0;
    end else begin
      addr_q    <= addr_d;
      cnt_q     <= cnt_d;
      len_q     <= len_d;
      mode_q    <= mode_d;
      cfg_err_q <= cfg_err_d;
    end
  end

  // Output logic
  always_comb begin
    addr       = addr_q;
    beat_cnt   = cnt_q;
    cfg_err    = cfg_err_q;
    addr_valid = (state_q == RUN);
    last       = (state_q == RUN) && is_last;
    busy       = (state_q == RUN) || (state_q == DONE);
    done       = (state_q == DONE);
  end

endmodule
